data_mem_access_unit: RTL and testbench
=======================================

// Module: data_mem_access_unit
// PURPOSE
//  RV64 load/store responder: executes memory requests the decoder marks with read/write + 3-bit width
//  ({unsigned, size[1:0]}; size 00=B 01=H 10=W 11=D). Sits between execute stage and data-memory bus.
//  Builds byte enables, replicates store data into lanes, handles bus wait states, returns extended load data.
// PARAMETERS
//  ADDR_W          32   byte-address width
//  TIMEOUT_CYCLES  255  max cycles waiting for mem_ack_in (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk_in          in   1       clock, all logic on rising edge
//  rst_n_in        in   1       asynchronous active-low reset
//  req_valid_in    in   1       request present from pipeline
//  ready_out       out  1       unit idle, request accepted this cycle if req_valid_in
//  read_in         in   1       load request
//  write_in        in   1       store request
//  width_in        in   3       {unsigned, size[1:0]}
//  addr_in         in   ADDR_W  byte address (ALU result)
//  wdata_in        in   64      store data (rs2), low bytes used
//  done_out        out  1       one-cycle completion pulse
//  rdata_out       out  64      extended load data, valid while done_out
//  misaligned_out  out  1       with done_out: address not size-aligned, no bus access
//  error_out       out  1       with done_out: illegal request or bus timeout
//  mem_req_out     out  1       bus request, held until ack
//  mem_we_out      out  1       bus write
//  mem_addr_out    out  ADDR_W  8-byte aligned address ({addr[ADDR_W-1:3],3'b0})
//  mem_be_out      out  8       byte enables
//  mem_wdata_out   out  64      lane-replicated store data
//  mem_ack_in      in   1       bus completion; mem_rdata_in valid same cycle
//  mem_rdata_in    in   64      bus read data (full doubleword)
// BEHAVIOUR
//  - States IDLE, ACCESS, RESP. ready_out = (state==IDLE), so 1 during/after reset.
//  - Reset: state IDLE; done/misaligned/error/mem_req/mem_we = 0; rdata/addr/be/wdata = 0. Async: mid-access
//    reset drops mem_req_out immediately, pending request discarded, no done_out.
//  - IDLE, req_valid_in=1, neither read nor write: ignored, stay IDLE.
//  - Illegal (read&write, or store with width[2]=1, or load width 3'b111): -> RESP, done_out+error_out, no bus.
//  - Misaligned (H: addr[0]!=0, W: addr[1:0]!=0, D: addr[2:0]!=0): -> RESP, done_out+misaligned_out, no bus.
//  - Legal: register addr/width/data, -> ACCESS. be = {1,3,F,FF}[size] << addr[2:0];
//    wdata replicated: B x8, H x4, W x2, D as-is. mem_we_out = write.
//  - ACCESS: mem_req_out=1 with stable addr/be/wdata/we until mem_ack_in. On ack -> RESP; load captures
//    mem_rdata_in >> (8*addr[2:0]), sign-extends (width[2]=0) or zero-extends (width[2]=1) from size.
//  - Store rdata_out = 0. mem_ack_in outside ACCESS ignored.
//  - RESP: done_out=1 for exactly one cycle, flags as above, -> IDLE. New request accepted next cycle.
//  - Latency: accept at T; mem_req_out T+1..T+1+k (ack at T+1+k); done_out at T+2+k. Error/misaligned: T+1.
//  - done/misaligned/error/mem_* registered; rdata_out holds until next done_out.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: cycle counter cleared on ACCESS entry; if TIMEOUT_CYCLES elapse without ack,
//    drop mem_req_out, -> RESP with done_out+error_out, rdata_out=0. Ack in the expiry cycle wins (normal done).
//  MEM_TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely; error_out only for illegal requests.
// TESTING
//  1 LB addr=0x1003, ack after 2 cycles, rdata_in=0x00000000_80000000 -> be=0x08, done T+4, rdata=0xFFFF..FF80.
//  2 LHU addr=0x1006, rdata_in=0xBEEF0000_00000000 -> be=0xC0, rdata=0x000000000000BEEF, no sign extension.
//  3 SW addr=0x2004 wdata=0x11223344 -> mem_we=1, be=0xF0, wdata_out=0x11223344_11223344, rdata_out=0.
//  4 LD addr=0x3004 -> done at T+1, misaligned_out=1, mem_req_out never asserted; same for SH addr=0x3001.
//  5 read_in=write_in=1, and SD width=3'b111 -> done T+1, error_out=1, no bus; then back-to-back LW accepted.
//  6 LW accepted, rst_n_in low during ACCESS -> mem_req_out=0 immediately, no done_out; with MEM_TIMEOUT_EN,
//    TIMEOUT_CYCLES=4, no ack -> error_out with done at T+6.

Source files
------------

// File: rtl/data_mem_access_unit.sv
// ---------------------------------------------------------------------------
// data_mem_access_unit
//   RV64 load/store responder between the execute stage and the data-memory
//   bus. Accepts one request at a time, validates it, builds byte enables and
//   lane-replicated store data, waits out bus wait states and returns
//   sign/zero-extended load data with a one-cycle done pulse.
//
// Ports
//   clk_in, rst_n_in           clock (rising edge), async active-low reset
//   req_valid_in / ready_out   pipeline request handshake
//   read_in, write_in          load / store
//   width_in                   {unsigned, size[1:0]}; size 00=B 01=H 10=W 11=D
//   addr_in, wdata_in          byte address, store data (low bytes used)
//   done_out                   one-cycle completion pulse
//   rdata_out                  extended load data (0 for stores/errors), holds
//   misaligned_out, error_out  completion flags, valid with done_out
//   mem_req_out .. mem_wdata_out  registered bus request fields
//   mem_ack_in, mem_rdata_in   bus completion and full-doubleword read data
//
// Handshakes
//   Pipeline: a request is taken on a rising edge where req_valid_in and
//   ready_out are both 1; ready_out is 1 only in IDLE. Bus: mem_req_out rises
//   with addr/be/wdata/we already valid and all of them stay stable until a
//   rising edge where mem_ack_in is 1; mem_rdata_in is sampled on that edge.
//   mem_ack_in outside ACCESS is ignored.
//
// Configuration
//   MEM_TIMEOUT_EN: when defined, an ACCESS that sees no ack for
//   TIMEOUT_CYCLES cycles is abandoned and completes with error_out.
// ---------------------------------------------------------------------------
module data_mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req_valid_in,
  output logic              ready_out,
  input  logic              read_in,
  input  logic              write_in,
  input  logic [2:0]        width_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [63:0]       wdata_in,
  output logic              done_out,
  output logic [63:0]       rdata_out,
  output logic              misaligned_out,
  output logic              error_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [7:0]        mem_be_out,
  output logic [63:0]       mem_wdata_out,
  input  logic              mem_ack_in,
  input  logic [63:0]       mem_rdata_in
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic                misaligned_q, misaligned_d;
  logic                error_q, error_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_be_q, mem_be_d;
  logic [63:0]         mem_wdata_q, mem_wdata_d;
  logic [63:0]         rdata_q, rdata_d;
  logic [2:0]          off_q, off_d;      // byte offset inside the doubleword
  logic [2:0]          width_q, width_d;

  logic                timeout_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // Counter starts at 0 in the first ACCESS cycle, so expiry lands after
  // exactly TIMEOUT_CYCLES+1 cycles of mem_req_out.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // Request decode
  logic [2:0]  req_off;
  logic [1:0]  req_size;
  logic        req_illegal;
  logic        req_misaligned;
  logic [7:0]  req_be;
  logic [63:0] req_wdata;

  assign req_off     = addr_in[2:0];
  assign req_size    = width_in[1:0];
  assign req_illegal = (read_in & write_in) | (write_in & width_in[2]) |
                       (read_in & (width_in == 3'b111));

  always_comb begin
    req_misaligned = 1'b0;
    req_be         = 8'h01;
    req_wdata      = wdata_in;
    unique case (req_size)
      2'b00: begin
        req_be    = 8'h01 << req_off;
        req_wdata = {8{wdata_in[7:0]}};
      end
      2'b01: begin
        req_misaligned = req_off[0];
        req_be         = 8'h03 << req_off;
        req_wdata      = {4{wdata_in[15:0]}};
      end
      2'b10: begin
        req_misaligned = |req_off[1:0];
        req_be         = 8'h0F << req_off;
        req_wdata      = {2{wdata_in[31:0]}};
      end
      default: begin
        req_misaligned = |req_off;
        req_be         = 8'hFF;
        req_wdata      = wdata_in;
      end
    endcase
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  logic [63:0] shifted;
  logic        sx;
  logic [63:0] load_ext;

  assign shifted = mem_rdata_in >> {off_q, 3'b000};
  assign sx      = ~width_q[2];

  always_comb begin
    load_ext = shifted;
    unique case (width_q[1:0])
      2'b00:   load_ext = {{56{sx & shifted[7]}},  shifted[7:0]};
      2'b01:   load_ext = {{48{sx & shifted[15]}}, shifted[15:0]};
      2'b10:   load_ext = {{32{sx & shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // Next state
  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    misaligned_d = 1'b0;
    error_d      = 1'b0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    off_d        = off_q;
    width_d      = width_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // A valid request with neither read nor write is dropped silently.
        if (req_valid_in && (read_in || write_in)) begin
          if (req_illegal) begin
            state_d = S_RESP;
            done_d  = 1'b1;
            error_d = 1'b1;
            rdata_d = '0;
          end else if (req_misaligned) begin
            state_d      = S_RESP;
            done_d       = 1'b1;
            misaligned_d = 1'b1;
            rdata_d      = '0;
          end else begin
            state_d     = S_ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = write_in;
            mem_addr_d  = {addr_in[ADDR_W-1:3], 3'b000};
            mem_be_d    = req_be;
            mem_wdata_d = req_wdata;
            off_d       = req_off;
            width_d     = width_in;
`ifdef MEM_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      S_ACCESS: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (mem_ack_in) begin
          state_d   = S_RESP;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          rdata_d   = mem_we_q ? 64'd0 : load_ext;
        end else if (timeout_hit) begin
          state_d   = S_RESP;
          done_d    = 1'b1;
          error_d   = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          rdata_d   = '0;
        end else begin
`ifdef MEM_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      error_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      off_q        <= '0;
      width_q      <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      misaligned_q <= misaligned_d;
      error_q      <= error_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      off_q        <= off_d;
      width_q      <= width_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign ready_out      = (state_q == S_IDLE);
  assign done_out       = done_q;
  assign misaligned_out = misaligned_q;
  assign error_out      = error_q;
  assign rdata_out      = rdata_q;
  assign mem_req_out    = mem_req_q;
  assign mem_we_out     = mem_we_q;
  assign mem_addr_out   = mem_addr_q;
  assign mem_be_out     = mem_be_q;
  assign mem_wdata_out  = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_data_mem_access_unit
//   Directed bench for data_mem_access_unit: a table of hand-computed load /
//   store / misaligned / illegal vectors, followed by short sequences for
//   reset, ignored requests, stray acks, rdata hold and (when built with
//   MEM_TIMEOUT_EN) the bus timeout.
// ---------------------------------------------------------------------------
module tb_data_mem_access_unit;

  localparam int ADDR_W = 32;
  localparam int K_BUS  = 0;
  localparam int K_MIS  = 1;
  localparam int K_ERR  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid, ready_out, rd, wr;
  logic [2:0]        width;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       wdata;
  logic              done_out, misaligned_out, error_out;
  logic [63:0]       rdata_out;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_be;
  logic [63:0]       mem_wdata, mem_rdata;

  data_mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(req_valid), .ready_out(ready_out),
    .read_in(rd), .write_in(wr), .width_in(width),
    .addr_in(addr), .wdata_in(wdata),
    .done_out(done_out), .rdata_out(rdata_out),
    .misaligned_out(misaligned_out), .error_out(error_out),
    .mem_req_out(mem_req), .mem_we_out(mem_we), .mem_addr_out(mem_addr),
    .mem_be_out(mem_be), .mem_wdata_out(mem_wdata),
    .mem_ack_in(mem_ack), .mem_rdata_in(mem_rdata)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  width;
    logic [31:0] addr;
    logic [63:0] wdata;
    int          ack_dly;
    logic [63:0] rdata_in;
    int          kind;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [7:0]  exp_be;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic w, input logic [2:0] wd,
                              input logic [31:0] a, input logic [63:0] d, input int dly,
                              input logic [63:0] rin, input int kind, input logic ewe,
                              input logic [31:0] ea, input logic [7:0] ebe,
                              input logic [63:0] ewd, input logic [63:0] erd);
    vec_t v;
    v.rd = r; v.wr = w; v.width = wd; v.addr = a; v.wdata = d; v.ack_dly = dly;
    v.rdata_in = rin; v.kind = kind; v.exp_we = ewe; v.exp_addr = ea;
    v.exp_be = ebe; v.exp_wdata = ewd; v.exp_rdata = erd;
    return v;
  endfunction

  vec_t vecs[17];

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    req_valid = 1'b0; rd = 1'b0; wr = 1'b0; width = 3'b000;
    addr = '0; wdata = '0;
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after the
  // done pulse, ready for the next back-to-back request.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, "_ready"}, 64'(ready_out), 64'd1);
    req_valid = 1'b1; rd = v.rd; wr = v.wr; width = v.width;
    addr = v.addr; wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    if (v.kind == K_BUS) begin
      exp_q.push_back(v.exp_rdata);
      chk({tag, "_req"},   64'(mem_req),   64'd1);
      chk({tag, "_we"},    64'(mem_we),    64'(v.exp_we));
      chk({tag, "_addr"},  64'(mem_addr),  64'(v.exp_addr));
      chk({tag, "_be"},    64'(mem_be),    64'(v.exp_be));
      chk({tag, "_wdata"}, mem_wdata,      v.exp_wdata);
      for (int i = 0; i < v.ack_dly; i++) begin
        @(negedge clk);
        chk({tag, "_hold"}, {mem_req, done_out, mem_be, mem_addr},
            {1'b1, 1'b0, v.exp_be, v.exp_addr});
      end
      mem_ack = 1'b1; mem_rdata = v.rdata_in;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 64'hA5A5_5A5A_A5A5_5A5A;
      chk({tag, "_done"},  64'(done_out),       64'd1);
      chk({tag, "_flags"}, {misaligned_out, error_out, mem_req}, 3'b000);
      chk({tag, "_rdata"}, rdata_out, exp_q.pop_front());
    end else begin
      chk({tag, "_done"},  64'(done_out), 64'd1);
      chk({tag, "_flags"}, {misaligned_out, error_out, mem_req},
          {v.kind == K_MIS, v.kind == K_ERR, 1'b0});
      chk({tag, "_rdata"}, rdata_out, 64'd0);
    end
    @(negedge clk);
    chk({tag, "_pulse"}, {done_out, ready_out}, 2'b01);
  endtask

  // ---------------- test ----------------
  initial begin
    int   done_seen;
    logic req_seen;

    //                rd wr  width    addr          wdata                   dly rdata_in                kind   we  exp_addr      be     exp_wdata               exp_rdata
    vecs[0]  = mk(1, 0, 3'b000, 32'h1003, 64'h0,                  2, 64'h00000000_80000000, K_BUS, 0, 32'h1000, 8'h08, 64'h0, 64'hFFFFFFFF_FFFFFF80);
    vecs[1]  = mk(1, 0, 3'b101, 32'h1006, 64'h0,                  0, 64'hBEEF0000_00000000, K_BUS, 0, 32'h1000, 8'hC0, 64'h0, 64'h00000000_0000BEEF);
    vecs[2]  = mk(0, 1, 3'b010, 32'h2004, 64'hDEADBEEF_11223344,  1, 64'hFFFFFFFF_FFFFFFFF, K_BUS, 1, 32'h2000, 8'hF0, 64'h11223344_11223344, 64'h0);
    vecs[3]  = mk(1, 0, 3'b011, 32'h3004, 64'h0,                  0, 64'h0,                 K_MIS, 0, 32'h0,    8'h00, 64'h0, 64'h0);
    vecs[4]  = mk(0, 1, 3'b001, 32'h3001, 64'h1234,               0, 64'h0,                 K_MIS, 0, 32'h0,    8'h00, 64'h0, 64'h0);
    vecs[5]  = mk(1, 1, 3'b011, 32'h3000, 64'h0,                  0, 64'h0,                 K_ERR, 0, 32'h0,    8'h00, 64'h0, 64'h0);
    vecs[6]  = mk(0, 1, 3'b111, 32'h3000, 64'h0,                  0, 64'h0,                 K_ERR, 0, 32'h0,    8'h00, 64'h0, 64'h0);
    vecs[7]  = mk(1, 0, 3'b010, 32'h0008, 64'h0,                  0, 64'h12345678_87654321, K_BUS, 0, 32'h0008, 8'h0F, 64'h0, 64'hFFFFFFFF_87654321);
    vecs[8]  = mk(1, 0, 3'b110, 32'h000C, 64'h0,                  3, 64'h87654321_00000000, K_BUS, 0, 32'h0008, 8'hF0, 64'h0, 64'h00000000_87654321);
    vecs[9]  = mk(0, 1, 3'b000, 32'h4007, 64'h00000000_000000AB,  0, 64'h0,                 K_BUS, 1, 32'h4000, 8'h80, 64'hABABABAB_ABABABAB, 64'h0);
    vecs[10] = mk(0, 1, 3'b001, 32'h4002, 64'h00000000_0000CAFE,  0, 64'h0,                 K_BUS, 1, 32'h4000, 8'h0C, 64'hCAFECAFE_CAFECAFE, 64'h0);
    vecs[11] = mk(0, 1, 3'b011, 32'h4008, 64'h01234567_89ABCDEF,  1, 64'h0,                 K_BUS, 1, 32'h4008, 8'hFF, 64'h01234567_89ABCDEF, 64'h0);
    vecs[12] = mk(1, 0, 3'b001, 32'h5002, 64'h0,                  0, 64'h00000000_80010000, K_BUS, 0, 32'h5000, 8'h0C, 64'h0, 64'hFFFFFFFF_FFFF8001);
    vecs[13] = mk(1, 0, 3'b010, 32'h5002, 64'h0,                  0, 64'h0,                 K_MIS, 0, 32'h0,    8'h00, 64'h0, 64'h0);
    vecs[14] = mk(1, 0, 3'b111, 32'h5000, 64'h0,                  0, 64'h0,                 K_ERR, 0, 32'h0,    8'h00, 64'h0, 64'h0);
    vecs[15] = mk(0, 1, 3'b100, 32'h5000, 64'h0,                  0, 64'h0,                 K_ERR, 0, 32'h0,    8'h00, 64'h0, 64'h0);
    vecs[16] = mk(1, 0, 3'b100, 32'h5005, 64'h0,                  0, 64'h0000F000_00000000, K_BUS, 0, 32'h5000, 8'h20, 64'h0, 64'h00000000_000000F0);

    drive_idle();
    mem_ack = 1'b0; mem_rdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_ctrl", {done_out, misaligned_out, error_out, mem_req, mem_we}, 5'b0);
    chk("rst_data", rdata_out | mem_wdata | 64'(mem_addr) | 64'(mem_be), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Request with neither read nor write is ignored; stray ack is ignored
    req_valid = 1'b1; mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("ignore", {ready_out, done_out, mem_req, error_out}, 4'b1000);
    chk("ignore_rdata", rdata_out, 64'd0);
    drive_idle(); mem_ack = 1'b0;

    // Table
    for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

    // rdata_out holds the last load result while idle
    repeat (2) @(negedge clk);
    chk("rdata_hold", rdata_out, 64'h00000000_000000F0);

    // Async reset in the middle of an access
    req_valid = 1'b1; rd = 1'b1; width = 3'b010; addr = 32'h0000_0010;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    chk("mid_req", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {mem_req, ready_out, done_out}, 3'b010);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    req_seen  = 1'b0;
    mem_ack   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done_out) done_seen++;
      req_seen = req_seen | mem_req;
    end
    mem_ack = 1'b0;
    chk("mid_nodone", 64'(done_seen), 64'd0);
    chk("mid_noreq", 64'(req_seen), 64'd0);

`ifdef MEM_TIMEOUT_EN
    // Timeout with TIMEOUT_CYCLES=4: accept at T, done+error at T+6
    req_valid = 1'b1; rd = 1'b1; width = 3'b010; addr = 32'h0000_0020;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    repeat (4) @(negedge clk);
    chk("to_wait", {mem_req, done_out}, 2'b10);
    @(negedge clk);
    chk("to_done", {done_out, error_out, misaligned_out, mem_req}, 4'b1100);
    chk("to_rdata", rdata_out, 64'd0);
    @(negedge clk);
`endif

    chk("final_ready", {ready_out, done_out}, 2'b10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so a stuck bench still terminates
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
